// File: rtl/key_entry_ctrl.sv
// key_entry_ctrl: keypad consumer. Builds a 4-digit BCD MM:SS value from key
// strobes. An idle timeout counted in 1 ms pulses discards the entry. Also
// issues start/stop toggle requests and hands the committed value to the
// timer core over a valid/ack handshake.
//
// Optional build macro KEY_ENTRY_RANGE_CHECK_EN: when defined, a SET whose
// minutes or seconds tens digit exceeds 5 is rejected with a one-cycle o_err
// pulse and the edit stays open. When undefined, o_err is tied low and
// every SET commits.
module key_entry_ctrl #(
    parameter int TIMEOUT_MS = 5000,
    parameter int TO_W       = 13
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_pls_1k,
    input  logic        i_key_valid,
    input  logic [4:0]  i_bcd_data,
    input  logic        i_set_ack,
    output logic [15:0] o_set_value,
    output logic        o_set_valid,
    output logic [15:0] o_disp_value,
    output logic        o_edit_active,
    output logic        o_start_stop,
    output logic        o_timeout,
    output logic        o_err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EDIT   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    localparam logic [4:0]      KEY_SET = 5'd10;
    localparam logic [4:0]      KEY_CLR = 5'd11;
    localparam logic [4:0]      KEY_SS  = 5'd12;
    // The timeout fires on the pulse that would bring the count to TIMEOUT_MS.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_MS - 1);

    state_t         r_state;
    logic [15:0]    r_buf;
    logic [2:0]     r_cnt;
    logic [TO_W-1:0] r_to_cnt;
    logic [15:0]    r_set_value;
    logic           r_set_valid;
    logic           r_start_stop;
    logic           r_timeout;

    logic           w_is_digit;
    logic           w_is_set;
    logic           w_is_clr;
    logic           w_is_ss;
    logic [3:0]     w_digit;

    // Decode the key code; only strobed cycles count, codes 13-31 match nothing.
    always_comb begin
        w_is_digit = i_key_valid && (i_bcd_data <= 5'd9);
        w_is_set   = i_key_valid && (i_bcd_data == KEY_SET);
        w_is_clr   = i_key_valid && (i_bcd_data == KEY_CLR);
        w_is_ss    = i_key_valid && (i_bcd_data == KEY_SS);
        w_digit    = i_bcd_data[3:0];
    end

`ifdef KEY_ENTRY_RANGE_CHECK_EN
    logic r_err;
    logic w_range_ok;

    // Minutes and seconds tens digits must both be 0-5 for a legal MM:SS.
    always_comb begin
        w_range_ok = (r_buf[15:12] <= 4'd5) && (r_buf[7:4] <= 4'd5);
    end
`endif

    // Entry state machine: edit buffer, timeout counter, handshake and pulses.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state      <= ST_IDLE;
            r_buf        <= 16'h0000;
            r_cnt        <= 3'd0;
            r_to_cnt     <= '0;
            r_set_value  <= 16'h0000;
            r_set_valid  <= 1'b0;
            r_start_stop <= 1'b0;
            r_timeout    <= 1'b0;
`ifdef KEY_ENTRY_RANGE_CHECK_EN
            r_err        <= 1'b0;
`endif
        end else begin
            r_start_stop <= 1'b0;
            r_timeout    <= 1'b0;
`ifdef KEY_ENTRY_RANGE_CHECK_EN
            r_err        <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (w_is_digit) begin
                        r_buf    <= {12'h000, w_digit};
                        r_cnt    <= 3'd1;
                        r_to_cnt <= '0;
                        r_state  <= ST_EDIT;
                    end else if (w_is_ss) begin
                        r_start_stop <= 1'b1;
                    end
                end
                ST_EDIT: begin
                    // Key handling takes priority over a coincident 1 ms pulse.
                    if (w_is_digit) begin
                        r_buf    <= {r_buf[11:0], w_digit};
                        r_to_cnt <= '0;
                        if (r_cnt != 3'd4) begin
                            r_cnt <= r_cnt + 3'd1;
                        end
                    end else if (w_is_clr) begin
                        r_buf    <= 16'h0000;
                        r_cnt    <= 3'd0;
                        r_to_cnt <= '0;
                        r_state  <= ST_IDLE;
                    end else if (w_is_set) begin
                        r_to_cnt <= '0;
`ifdef KEY_ENTRY_RANGE_CHECK_EN
                        if (!w_range_ok) begin
                            r_err <= 1'b1;
                        end else begin
                            r_set_value <= r_buf;
                            r_set_valid <= 1'b1;
                            r_state     <= ST_COMMIT;
                        end
`else
                        r_set_value <= r_buf;
                        r_set_valid <= 1'b1;
                        r_state     <= ST_COMMIT;
`endif
                    end else if (i_pls_1k) begin
                        if (r_to_cnt == TO_LAST) begin
                            r_buf     <= 16'h0000;
                            r_cnt     <= 3'd0;
                            r_to_cnt  <= '0;
                            r_timeout <= 1'b1;
                            r_state   <= ST_IDLE;
                        end else begin
                            r_to_cnt <= r_to_cnt + 1'b1;
                        end
                    end
                end
                ST_COMMIT: begin
                    // Value and valid hold until the timer core acknowledges.
                    if (i_set_ack) begin
                        r_set_valid <= 1'b0;
                        r_buf       <= 16'h0000;
                        r_cnt       <= 3'd0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_set_value   = r_set_value;
    assign o_set_valid   = r_set_valid;
    assign o_disp_value  = r_buf;
    assign o_edit_active = (r_state == ST_EDIT);
    assign o_start_stop  = r_start_stop;
    assign o_timeout     = r_timeout;
`ifdef KEY_ENTRY_RANGE_CHECK_EN
    assign o_err         = r_err;
`else
    assign o_err         = 1'b0;
`endif

endmodule
